// File: rtl/gpio_f2m_pkg.sv
// ---------------------------------------------------------------------------
// gpio_f2m_pkg
// Shared definitions for the fabric-to-MSS GPIO serial link: the transmit
// FSM state encoding and the default frame width / acknowledge timeout used
// by gpio_f2m_tx.
// ---------------------------------------------------------------------------
package gpio_f2m_pkg;

  // Default frame width in bits (legal range 1..32).
  localparam int GPIO_F2M_DATA_W  = 8;

  // Default number of clock cycles to wait for one bit acknowledge
  // (legal range 1..65535).
  localparam int GPIO_F2M_TIMEOUT = 1023;

  // Transmit FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    STROBE   = 2'd2,
    WAIT_ACK = 2'd3
  } gpio_f2m_state_t;

endpackage

// File: rtl/gpio_sync2.sv
// ---------------------------------------------------------------------------
// gpio_sync2
// Two-flop synchronizer for a single-bit level coming from the MSS clock
// domain. Usable for any M2F GPIO input.
//
// Ports:
//   clk    in   destination clock, rising edge
//   rst_n  in   asynchronous active-low reset, forces both flops to RESET_VAL
//   d      in   asynchronous input level
//   q      out  synchronized level (two clock cycles of latency)
// ---------------------------------------------------------------------------
module gpio_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives it a full cycle to settle
  // before anything downstream looks at the value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gpio_f2m_tx.sv
// ---------------------------------------------------------------------------
// gpio_f2m_tx
// Serialises a DATA_W-bit frame, LSB first, onto one GPIO data line towards
// the MSS. Each bit is handed over with a two-phase toggle handshake: the
// strobe output toggles once per bit and the MSS answers by making its
// acknowledge line equal to the strobe. A bit that is not acknowledged
// within TIMEOUT wait cycles aborts the frame and sets a sticky error.
//
// Ports:
//   FAB_CCC_GL0    in   clock, all logic on the rising edge
//   FAB_RESET_N    in   asynchronous active-low reset
//   TX_DATA        in   frame to send, captured on accept
//   TX_VALID       in   TX_DATA holds a frame
//   TX_READY       out  block can accept a frame this cycle
//   GPIO_ACK_M2F   in   acknowledge toggle from the MSS (asynchronous)
//   GPIO_DATA_F2M  out  serial data bit
//   GPIO_STRB_F2M  out  strobe toggle, one toggle per bit
//   BUSY           out  a frame is in progress
//   TIMEOUT_ERR    out  sticky, set when a frame is aborted
//   ERR_CLR        in   single-cycle clear of TIMEOUT_ERR
// ---------------------------------------------------------------------------
module gpio_f2m_tx
  import gpio_f2m_pkg::*;
#(
  parameter int DATA_W  = GPIO_F2M_DATA_W,
  parameter int TIMEOUT = GPIO_F2M_TIMEOUT
) (
  input  logic              FAB_CCC_GL0,
  input  logic              FAB_RESET_N,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  input  logic              GPIO_ACK_M2F,
  output logic              GPIO_DATA_F2M,
  output logic              GPIO_STRB_F2M,
  output logic              BUSY,
  output logic              TIMEOUT_ERR,
  input  logic              ERR_CLR
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT     = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  gpio_f2m_state_t   state;
  logic [DATA_W-1:0] shift_reg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  tout_cnt;
  logic              strb_q;
  logic              data_q;
  logic              err_q;
  logic              rst_done;
  logic              ack_s;
  logic              ack_matched;
  logic              accept;
  logic              timeout_hit;

  gpio_sync2 #(
    .RESET_VAL (1'b0)
  ) u_ack_sync (
    .clk   (FAB_CCC_GL0),
    .rst_n (FAB_RESET_N),
    .d     (GPIO_ACK_M2F),
    .q     (ack_s)
  );

  // With two-phase signalling there is no outstanding toggle exactly when the
  // synchronized acknowledge has caught up with the strobe.
  assign ack_matched = (ack_s == strb_q);

  // rst_done keeps READY low while reset is held; after that a new frame may
  // only start once any late acknowledge from an aborted frame has landed.
  assign TX_READY = rst_done && (state == IDLE) && ack_matched;
  assign accept   = TX_VALID && TX_READY;

  // The counter reaches TIMEOUT on this edge without an acknowledge. An
  // acknowledge seen in the same cycle wins and the bit completes normally.
  assign timeout_hit = (state == WAIT_ACK) && !ack_matched &&
                       (tout_cnt == TIMEOUT_LAST);

  assign GPIO_DATA_F2M = data_q;
  assign GPIO_STRB_F2M = strb_q;
  assign BUSY          = (state != IDLE);
  assign TIMEOUT_ERR   = err_q;

  // Transmit FSM. Per bit: SETUP drives the data bit, STROBE toggles the
  // strobe one cycle later, WAIT_ACK holds both until the MSS answers. The
  // data bit is only written in SETUP, so it stays stable across STROBE and
  // WAIT_ACK of the same bit. An abort leaves the strobe as it is, so the
  // late acknowledge still pairs with it and re-opens TX_READY.
  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      tout_cnt  <= '0;
      strb_q    <= 1'b0;
      data_q    <= 1'b0;
      rst_done  <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= TX_DATA;
            bit_cnt   <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          data_q <= shift_reg[0];
          state  <= STROBE;
        end
        STROBE: begin
          strb_q   <= ~strb_q;
          tout_cnt <= '0;
          state    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack_matched) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 1'b1;
            state     <= (bit_cnt == LAST_BIT) ? IDLE : SETUP;
          end else begin
            if (tout_cnt != TIMEOUT_MAX) begin
              tout_cnt <= tout_cnt + 1'b1;
            end
            if (timeout_hit) begin
              shift_reg <= '0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky abort flag; a timeout in the same cycle as ERR_CLR keeps it set.
  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end else if (ERR_CLR) begin
      err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpio_f2m_tx.sv
// ---------------------------------------------------------------------------
// tb_gpio_f2m_tx
// Self-checking bench for gpio_f2m_tx (DATA_W=8, TIMEOUT=15). An MSS model
// echoes each strobe toggle on the acknowledge line after a programmable
// delay and can be muted on a chosen toggle. Expected data bits are queued
// when a frame is issued and a monitor pops one per observed strobe toggle.
// ---------------------------------------------------------------------------
module tb_gpio_f2m_tx;

  logic       FAB_CCC_GL0 = 1'b0;
  logic       FAB_RESET_N = 1'b0;
  logic [7:0] TX_DATA     = 8'h00;
  logic       TX_VALID    = 1'b0;
  logic       TX_READY;
  logic       GPIO_ACK_M2F;
  logic       GPIO_DATA_F2M;
  logic       GPIO_STRB_F2M;
  logic       BUSY;
  logic       TIMEOUT_ERR;
  logic       ERR_CLR     = 1'b0;

  int total_checks = 0;
  int bad_checks   = 0;
  bit exp_q[$];

  // MSS model controls and state
  int   mss_delay  = 3;
  int   mute_at    = -1;
  logic unmute     = 1'b0;
  int   tog_count  = 0;
  logic last_seen  = 1'b0;
  logic pending    = 1'b0;
  int   wcnt       = 0;

  // Monitor state
  logic prev_strb   = 1'b0;
  int   mon_toggles = 0;

  gpio_f2m_tx #(
    .DATA_W  (8),
    .TIMEOUT (15)
  ) dut (
    .FAB_CCC_GL0   (FAB_CCC_GL0),
    .FAB_RESET_N   (FAB_RESET_N),
    .TX_DATA       (TX_DATA),
    .TX_VALID      (TX_VALID),
    .TX_READY      (TX_READY),
    .GPIO_ACK_M2F  (GPIO_ACK_M2F),
    .GPIO_DATA_F2M (GPIO_DATA_F2M),
    .GPIO_STRB_F2M (GPIO_STRB_F2M),
    .BUSY          (BUSY),
    .TIMEOUT_ERR   (TIMEOUT_ERR),
    .ERR_CLR       (ERR_CLR)
  );

  always #5 FAB_CCC_GL0 = ~FAB_CCC_GL0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_checks++;
    if (actual != expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present a frame, queue the data bits expected on the strobe toggles and
  // return just after the accepting clock edge.
  task automatic applyStimulus(input logic [7:0] d, input int nbits);
    int guard;
    @(negedge FAB_CCC_GL0);
    TX_DATA  = d;
    TX_VALID = 1'b1;
    for (int i = 0; i < nbits; i++) exp_q.push_back(d[i]);
    guard = 0;
    while (!TX_READY && guard < 100) begin
      @(negedge FAB_CCC_GL0);
      guard++;
    end
    checkOutput("accept_ready", int'(TX_READY), 1);
    @(posedge FAB_CCC_GL0);
    #1;
    TX_VALID = 1'b0;
  endtask

  // Count cycles with BUSY high, sampled on falling edges.
  task automatic measureBusy(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge FAB_CCC_GL0);
      if (!BUSY) break;
      n++;
    end
  endtask

  task automatic waitReady(input int limit);
    int guard;
    guard = 0;
    while (!TX_READY && guard < limit) begin
      @(negedge FAB_CCC_GL0);
      guard++;
    end
  endtask

  // MSS model: echoes a new strobe level onto the acknowledge line mss_delay
  // cycles after seeing it, unless that toggle is the muted one.
  initial begin
    GPIO_ACK_M2F = 1'b0;
    forever begin
      @(posedge FAB_CCC_GL0);
      #1;
      if (!FAB_RESET_N) begin
        GPIO_ACK_M2F = 1'b0;
        pending      = 1'b0;
        last_seen    = 1'b0;
      end else begin
        if (GPIO_STRB_F2M != last_seen) begin
          last_seen = GPIO_STRB_F2M;
          tog_count++;
        end
        if (pending) begin
          wcnt++;
          if (wcnt >= mss_delay) begin
            GPIO_ACK_M2F = last_seen;
            pending      = 1'b0;
          end
        end else if ((GPIO_ACK_M2F != GPIO_STRB_F2M) &&
                     ((tog_count != mute_at) || unmute)) begin
          pending = 1'b1;
          wcnt    = 0;
        end
      end
    end
  end

  // Monitor: every strobe toggle must carry the next queued data bit.
  initial begin
    forever begin
      @(negedge FAB_CCC_GL0);
      if (!FAB_RESET_N) begin
        prev_strb = GPIO_STRB_F2M;
      end else if (GPIO_STRB_F2M != prev_strb) begin
        prev_strb = GPIO_STRB_F2M;
        mon_toggles++;
        if (exp_q.size() == 0) begin
          checkOutput("strobe_without_queued_bit", 0, 1);
        end else begin
          checkOutput("data_bit", int'(GPIO_DATA_F2M), int'(exp_q.pop_front()));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int n;
    int t0;
    int guard;

    // Reset state
    repeat (3) @(negedge FAB_CCC_GL0);
    checkOutput("reset_tx_ready", int'(TX_READY), 0);
    checkOutput("reset_busy", int'(BUSY), 0);
    checkOutput("reset_strobe", int'(GPIO_STRB_F2M), 0);
    checkOutput("reset_data", int'(GPIO_DATA_F2M), 0);
    checkOutput("reset_err", int'(TIMEOUT_ERR), 0);
    FAB_RESET_N = 1'b1;
    repeat (3) @(negedge FAB_CCC_GL0);
    checkOutput("ready_after_reset", int'(TX_READY), 1);

    // Nominal frame 0xA5, echo after 3 cycles: 8 bits x (3+5) cycles
    $display("[TB] nominal frame 0xA5");
    t0 = mon_toggles;
    applyStimulus(8'hA5, 8);
    measureBusy(n);
    checkOutput("nominal_busy_cycles", n, 64);
    checkOutput("nominal_toggles", mon_toggles - t0, 8);
    checkOutput("nominal_err", int'(TIMEOUT_ERR), 0);
    checkOutput("nominal_bits_left", exp_q.size(), 0);

    // Back-to-back: TX_VALID held high, 0x01 then 0xFF
    $display("[TB] back-to-back frames 0x01, 0xFF");
    t0 = mon_toggles;
    @(negedge FAB_CCC_GL0);
    TX_DATA  = 8'h01;
    TX_VALID = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(i == 0);
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
    waitReady(100);
    checkOutput("b2b_first_ready", int'(TX_READY), 1);
    @(posedge FAB_CCC_GL0);
    #1;
    TX_DATA = 8'hFF;
    measureBusy(n);
    checkOutput("b2b_first_busy", n, 64);
    checkOutput("b2b_ready_first_idle", int'(TX_READY), 1);
    @(posedge FAB_CCC_GL0);
    #1;
    TX_VALID = 1'b0;
    measureBusy(n);
    checkOutput("b2b_second_busy", n, 64);
    checkOutput("b2b_toggles", mon_toggles - t0, 16);
    checkOutput("b2b_bits_left", exp_q.size(), 0);

    // Timeout: MSS silent on bit 2 -> 8 + 8 + (2 + 15) busy cycles
    $display("[TB] timeout on bit 2");
    t0 = mon_toggles;
    mute_at = tog_count + 3;
    applyStimulus(8'h3C, 3);
    measureBusy(n);
    checkOutput("timeout_busy_cycles", n, 33);
    checkOutput("timeout_err_set", int'(TIMEOUT_ERR), 1);
    repeat (5) @(negedge FAB_CCC_GL0);
    checkOutput("ready_held_after_abort", int'(TX_READY), 0);
    checkOutput("timeout_toggles", mon_toggles - t0, 3);
    checkOutput("timeout_bits_left", exp_q.size(), 0);
    unmute = 1'b1;
    waitReady(50);
    checkOutput("ready_after_late_ack", int'(TX_READY), 1);
    unmute  = 1'b0;
    mute_at = -1;

    // Lone clear
    @(negedge FAB_CCC_GL0);
    ERR_CLR = 1'b1;
    @(negedge FAB_CCC_GL0);
    ERR_CLR = 1'b0;
    checkOutput("err_cleared", int'(TIMEOUT_ERR), 0);

    // Collision: ERR_CLR in the exact cycle of a new timeout on bit 0.
    // Accept edge E0, strobe at E0+2, 15 wait cycles, abort at E0+17.
    $display("[TB] clear/timeout collision");
    mute_at = tog_count + 1;
    applyStimulus(8'h81, 1);
    repeat (16) @(posedge FAB_CCC_GL0);
    #1;
    checkOutput("busy_before_abort", int'(BUSY), 1);
    ERR_CLR = 1'b1;
    @(posedge FAB_CCC_GL0);
    #1;
    ERR_CLR = 1'b0;
    checkOutput("busy_after_abort", int'(BUSY), 0);
    checkOutput("collision_err_kept", int'(TIMEOUT_ERR), 1);
    unmute = 1'b1;
    waitReady(50);
    checkOutput("collision_ready_after_ack", int'(TX_READY), 1);
    unmute  = 1'b0;
    mute_at = -1;
    @(negedge FAB_CCC_GL0);
    ERR_CLR = 1'b1;
    @(negedge FAB_CCC_GL0);
    ERR_CLR = 1'b0;
    checkOutput("collision_err_cleared", int'(TIMEOUT_ERR), 0);
    checkOutput("collision_bits_left", exp_q.size(), 0);

    // Boundary: echo after 12 cycles -> ack on the 15th wait cycle, no abort
    $display("[TB] boundary acknowledge");
    mss_delay = 12;
    t0 = mon_toggles;
    applyStimulus(8'hC3, 8);
    measureBusy(n);
    checkOutput("boundary_busy_cycles", n, 136);
    checkOutput("boundary_err", int'(TIMEOUT_ERR), 0);
    checkOutput("boundary_toggles", mon_toggles - t0, 8);
    checkOutput("boundary_bits_left", exp_q.size(), 0);
    mss_delay = 3;

    // Reset mid-frame during bit 4 of 0x5A (bit 4 = 1, strobe = 1 by parity)
    $display("[TB] reset mid-frame");
    t0 = mon_toggles;
    applyStimulus(8'h5A, 8);
    guard = 0;
    while ((mon_toggles < t0 + 5) && guard < 200) begin
      @(negedge FAB_CCC_GL0);
      guard++;
    end
    checkOutput("reached_bit4", mon_toggles - t0, 5);
    checkOutput("strobe_before_reset", int'(GPIO_STRB_F2M), 1);
    checkOutput("data_before_reset", int'(GPIO_DATA_F2M), 1);
    #2;
    FAB_RESET_N = 1'b0;
    #1;
    checkOutput("async_reset_strobe", int'(GPIO_STRB_F2M), 0);
    checkOutput("async_reset_busy", int'(BUSY), 0);
    checkOutput("async_reset_data", int'(GPIO_DATA_F2M), 0);
    checkOutput("async_reset_ready", int'(TX_READY), 0);
    exp_q.delete();
    repeat (3) @(negedge FAB_CCC_GL0);
    FAB_RESET_N = 1'b1;
    t0 = mon_toggles;
    repeat (10) @(negedge FAB_CCC_GL0);
    checkOutput("no_toggle_after_reset", mon_toggles - t0, 0);
    checkOutput("ready_after_mid_reset", int'(TX_READY), 1);

    // Recovery frame
    $display("[TB] recovery frame 0x96");
    t0 = mon_toggles;
    applyStimulus(8'h96, 8);
    measureBusy(n);
    checkOutput("recovery_busy_cycles", n, 64);
    checkOutput("recovery_toggles", mon_toggles - t0, 8);
    checkOutput("recovery_bits_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
